// File: rtl/adc_frame_receiver.sv
// Word-sync framed deserializer for N_CH serial ADC lanes with frame-timing checks and lock tracking.
// Optional ADC_RX_TESTPAT_EN adds a test_mode input that replaces lane data with (frame_cnt + lane).

module adc_rx_lane #(
    parameter int DATA_BITS = 18
) (
    input  logic                 PLL_clk_100MHz,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 start,
    input  logic                 load,
    input  logic                 sdata,
    input  logic                 tp_en,
    input  logic [DATA_BITS-1:0] tp_word,
    output logic [DATA_BITS-1:0] word
);
    logic [DATA_BITS-1:0] shift_nxt;

    generate
        if (DATA_BITS == 1) begin : g_one
            assign shift_nxt = sdata;
        end else begin : g_multi
            logic [DATA_BITS-2:0] shreg;
            // start drops any partial word left over from an aborted frame
            assign shift_nxt = start ? {{(DATA_BITS-1){1'b0}}, sdata} : {shreg, sdata};
            always_ff @(posedge PLL_clk_100MHz or posedge rst) begin
                if (rst)            shreg <= '0;
                else if (sample_en) shreg <= shift_nxt[DATA_BITS-2:0];
            end
        end
    endgenerate

    always_ff @(posedge PLL_clk_100MHz or posedge rst) begin
        if (rst)       word <= '0;
        else if (load) word <= tp_en ? tp_word : shift_nxt;
    end
endmodule

module adc_frame_receiver #(
    parameter int N_CH        = 8,
    parameter int DATA_BITS   = 18,
    parameter int FRAME_CLKS  = 50,
    parameter int SYNC_WIDTH  = 5,
    parameter int CONV_OFFSET = 10,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                        PLL_clk_100MHz,
    input  logic                        rst,
    input  logic                        ADCs_word_sync,
    input  logic                        ADCs_start_conv,
    input  logic [N_CH-1:0]             adc_sdata,
    input  logic                        err_clr,
`ifdef ADC_RX_TESTPAT_EN
    input  logic                        test_mode,
`endif
    output logic [N_CH*DATA_BITS-1:0]   adc_data,
    output logic                        data_valid,
    output logic [15:0]                 frame_cnt,
    output logic                        locked,
    output logic [3:0]                  err_flags
);
    localparam int TO_CLKS = 2 * FRAME_CLKS;
    localparam int PCW     = $clog2(TO_CLKS + 1);
    localparam int BCW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int LCW     = $clog2(SYNC_WIDTH + 2);
    localparam int GCW     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {HUNT, SHIFT, DONE, WAIT} state_t;

    state_t             state, state_nxt;
    logic [BCW-1:0]     bit_cnt, bit_nxt, idx;
    logic               sample_en, start, load, overrun;
    logic               ws_prev, sc_prev, fall, rise, sc_fall, timeout;
    logic [PCW-1:0]     per_cnt;
    logic               per_valid, seen_fall;
    logic [LCW-1:0]     low_cnt;
    logic               width_ok;
    logic [GCW-1:0]     good_cnt;
    logic [3:0]         err_set;
    logic               good_fall;
    logic               tp_en;
    logic [N_CH-1:0][DATA_BITS-1:0] tp_word, lane_word;

    assign fall    = ws_prev & ~ADCs_word_sync;
    assign rise    = ~ws_prev & ADCs_word_sync;
    assign sc_fall = sc_prev & ~ADCs_start_conv;
    assign timeout = ~fall && (32'(per_cnt) + 1 == TO_CLKS);

    always_ff @(posedge PLL_clk_100MHz or posedge rst) begin
        if (rst) begin
            state   <= HUNT;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    // A fall always starts a word, whatever the state; DONE has already delivered its word.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        idx       = bit_cnt;
        sample_en = 1'b0;
        start     = 1'b0;
        load      = 1'b0;
        overrun   = 1'b0;
        if (timeout) begin
            state_nxt = HUNT;
            bit_nxt   = '0;
        end else begin
            if (fall) begin
                sample_en = 1'b1;
                start     = 1'b1;
                idx       = '0;
                overrun   = (state == SHIFT);
            end else if (state == SHIFT) begin
                sample_en = 1'b1;
            end else if (state == DONE) begin
                state_nxt = WAIT;
            end
            if (sample_en) begin
                if (idx == BCW'(DATA_BITS - 1)) begin
                    load      = 1'b1;
                    state_nxt = DONE;
                    bit_nxt   = '0;
                end else begin
                    state_nxt = SHIFT;
                    bit_nxt   = idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        err_set    = 4'b0;
        err_set[0] = fall && per_valid && (32'(per_cnt) + 1 != FRAME_CLKS);
        err_set[1] = rise && (32'(low_cnt) != SYNC_WIDTH);
        err_set[2] = overrun;
        err_set[3] = sc_fall && seen_fall &&
                     (fall ? (CONV_OFFSET != 0) : (32'(per_cnt) + 1 != CONV_OFFSET));
    end

    assign good_fall = fall && per_valid && !err_set[0] && width_ok;

    always_ff @(posedge PLL_clk_100MHz or posedge rst) begin
        if (rst) begin
            ws_prev   <= 1'b1;
            sc_prev   <= 1'b1;
            per_cnt   <= '0;
            per_valid <= 1'b0;
            seen_fall <= 1'b0;
            low_cnt   <= '0;
            width_ok  <= 1'b0;
        end else begin
            ws_prev <= ADCs_word_sync;
            sc_prev <= ADCs_start_conv;
            if (fall)                          per_cnt <= '0;
            else if (32'(per_cnt) < TO_CLKS)   per_cnt <= per_cnt + 1'b1;
            if (fall)         per_valid <= 1'b1;
            else if (timeout) per_valid <= 1'b0;
            if (fall) seen_fall <= 1'b1;
            // low_cnt saturates one past the target so any over-long pulse still mismatches
            if (fall)
                low_cnt <= LCW'(1);
            else if (!ADCs_word_sync && !ws_prev && 32'(low_cnt) <= SYNC_WIDTH)
                low_cnt <= low_cnt + 1'b1;
            if (fall)      width_ok <= 1'b0;
            else if (rise) width_ok <= (32'(low_cnt) == SYNC_WIDTH);
        end
    end

    always_ff @(posedge PLL_clk_100MHz or posedge rst) begin
        if (rst) begin
            good_cnt  <= '0;
            locked    <= 1'b0;
            err_flags <= 4'b0;
        end else begin
            err_flags <= (err_clr ? 4'b0 : err_flags) | err_set;
            if (|err_set || timeout) begin
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (good_fall) begin
                if (32'(good_cnt) < LOCK_FRAMES) good_cnt <= good_cnt + 1'b1;
                if (32'(good_cnt) + 1 >= LOCK_FRAMES) locked <= 1'b1;
            end
        end
    end

    always_ff @(posedge PLL_clk_100MHz or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            data_valid <= load;
            if (load) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef ADC_RX_TESTPAT_EN
    assign tp_en = test_mode;
    for (genvar k = 0; k < N_CH; k++) begin : g_tp
        logic [16:0] tp_sum;
        assign tp_sum     = {1'b0, frame_cnt} + 17'(k);
        assign tp_word[k] = DATA_BITS'(tp_sum);
    end
`else
    assign tp_en   = 1'b0;
    assign tp_word = '0;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        adc_rx_lane #(.DATA_BITS(DATA_BITS)) u_lane (
            .PLL_clk_100MHz (PLL_clk_100MHz),
            .rst            (rst),
            .sample_en      (sample_en),
            .start          (start),
            .load           (load),
            .sdata          (adc_sdata[k]),
            .tp_en          (tp_en),
            .tp_word        (tp_word[k]),
            .word           (lane_word[k])
        );
    end

    assign adc_data = lane_word;
endmodule

// File: tb/tb_adc_frame_receiver.sv
// Randomized frame-level stimulus with a scoreboard of expected words and a frame-level lock/error model.
module tb_adc_frame_receiver;
    localparam int N_CH = 8, DB = 18, FRAME = 50, SW = 5, CO = 10, LOCKF = 4;

    typedef logic [N_CH-1:0][DB-1:0] words_t;
    typedef struct {
        words_t      data;
        logic [15:0] fc;
        int          cyc;
    } exp_t;

    logic                 PLL_clk_100MHz = 1'b0;
    logic                 rst, ADCs_word_sync, ADCs_start_conv, err_clr;
    logic [N_CH-1:0]      adc_sdata;
    logic [N_CH*DB-1:0]   adc_data;
    logic                 data_valid, locked;
    logic [15:0]          frame_cnt;
    logic [3:0]           err_flags;
`ifdef ADC_RX_TESTPAT_EN
    logic                 test_mode = 1'b0;
`endif

    adc_frame_receiver dut (
        .PLL_clk_100MHz  (PLL_clk_100MHz),
        .rst             (rst),
        .ADCs_word_sync  (ADCs_word_sync),
        .ADCs_start_conv (ADCs_start_conv),
        .adc_sdata       (adc_sdata),
        .err_clr         (err_clr),
`ifdef ADC_RX_TESTPAT_EN
        .test_mode       (test_mode),
`endif
        .adc_data        (adc_data),
        .data_valid      (data_valid),
        .frame_cnt       (frame_cnt),
        .locked          (locked),
        .err_flags       (err_flags)
    );

    always #5 PLL_clk_100MHz = ~PLL_clk_100MHz;

    int cyc = 0;
    always @(posedge PLL_clk_100MHz) cyc <= cyc + 1;

    exp_t sb[$];
    int errors = 0, checks = 0;

    // frame-level reference state
    logic [3:0]  m_err = 4'b0;
    int          m_good = 0;
    logic        m_locked = 1'b0;
    bit          m_pv = 1'b0;
    int          m_pp = 0;
    bit          m_pwok = 1'b0;
    logic [15:0] m_fc = 16'd0;
    bit          tm_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge PLL_clk_100MHz) begin
        if (data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_valid=1 expected none (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (adc_data !== e.data) begin
                    errors++;
                    $display("FAIL adc_data: got %h expected %h", adc_data, e.data);
                end
                chk("frame_cnt_at_valid", 64'(frame_cnt), 64'(e.fc));
                chk("valid_latency_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_adc_data_zero", 64'(adc_data != '0), 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err_flags", 64'(err_flags), 64'd0);
    endtask

    // One frame: sync fall at cycle 0, low for w, start_conv fall at conv, next fall after p clocks.
    task automatic frame(input int p, input int w, input int conv, input int clr_at,
                         input bit abort, input words_t words);
        words_t exp_w;
        bit     fall_err;
        exp_t   e;
        fall_err = 1'b0;
        if (m_pv && m_pp != FRAME) begin m_err[0] = 1'b1; fall_err = 1'b1; end
        if (m_pv && m_pp < DB)     begin m_err[2] = 1'b1; fall_err = 1'b1; end
        if (fall_err) begin
            m_good = 0; m_locked = 1'b0;
        end else if (m_pv && m_pwok) begin
            if (m_good < LOCKF) m_good++;
            if (m_good >= LOCKF) m_locked = 1'b1;
        end
        if (w != SW)    begin m_err[1] = 1'b1; m_good = 0; m_locked = 1'b0; end
        m_pwok = (w == SW);
        if (conv != CO) begin m_err[3] = 1'b1; m_good = 0; m_locked = 1'b0; end
        if (clr_at >= 0) m_err = 4'b0;
        if (p >= 2 * FRAME) begin m_good = 0; m_locked = 1'b0; m_pv = 1'b0; end
        else m_pv = 1'b1;
        m_pp = p;
        for (int k = 0; k < N_CH; k++)
            exp_w[k] = tm_on ? DB'(32'(m_fc) + k) : words[k];

        for (int c = 0; c < p; c++) begin
            @(negedge PLL_clk_100MHz);
            if (c == p - 1) begin
                chk("err_flags", 64'(err_flags), 64'(m_err));
                chk("locked", 64'(locked), 64'(m_locked));
                if (p > DB) chk("frame_cnt_end", 64'(frame_cnt), 64'(m_fc));
            end
            if (c == 0 && !abort && p >= DB) begin
                e.data = exp_w; e.fc = m_fc + 16'd1; e.cyc = cyc + DB;
                sb.push_back(e);
                m_fc = m_fc + 16'd1;
            end
`ifdef ADC_RX_TESTPAT_EN
            test_mode = tm_on;
`endif
            ADCs_word_sync  = (c < w) ? 1'b0 : 1'b1;
            ADCs_start_conv = (c >= conv && c < conv + 3) ? 1'b0 : 1'b1;
            err_clr         = (c == clr_at);
            for (int k = 0; k < N_CH; k++)
                adc_sdata[k] = (c < DB) ? words[k][DB-1-c] : 1'($urandom);
            if (abort && c == 9) begin
                rst = 1'b1;
                m_err = 4'b0; m_good = 0; m_locked = 1'b0; m_pv = 1'b0; m_fc = 16'd0;
            end
            if (abort && c == 10) chk_reset_outputs();
            if (abort && c == 11) rst = 1'b0;
        end
    endtask

    function automatic words_t rnd_words();
        words_t w;
        for (int k = 0; k < N_CH; k++) w[k] = DB'($urandom);
        return w;
    endfunction

    initial begin
        words_t nom;
        int p, w, conv, clr, r;
        for (int k = 0; k < N_CH; k++) nom[k] = 18'h2A5A5 + DB'(k);
        rst = 1'b1; ADCs_word_sync = 1'b1; ADCs_start_conv = 1'b1; err_clr = 1'b0; adc_sdata = '0;
        repeat (3) @(negedge PLL_clk_100MHz);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (4) @(negedge PLL_clk_100MHz);

        repeat (6) frame(FRAME, SW, CO, -1, 1'b0, nom);           // nominal, lock
        frame(49, SW, CO, -1, 1'b0, rnd_words());                  // short period
        repeat (5) frame(FRAME, SW, CO, -1, 1'b0, rnd_words());
        frame(FRAME, SW, CO, 45, 1'b0, rnd_words());               // clear period error
        frame(10, SW, 5, -1, 1'b0, rnd_words());                   // overrun
        repeat (2) frame(FRAME, SW, CO, -1, 1'b0, nom);
        frame(FRAME, 6, CO, -1, 1'b0, rnd_words());                // wide sync
        frame(FRAME, SW, 11, -1, 1'b0, rnd_words());               // late start_conv
        frame(DB, SW, CO, -1, 1'b0, rnd_words());                  // fall coincides with DONE
        frame(FRAME, SW, CO, 45, 1'b0, rnd_words());
        frame(120, SW, CO, -1, 1'b0, rnd_words());                 // timeout
        repeat (2) frame(FRAME, SW, CO, -1, 1'b0, rnd_words());
        frame(FRAME, SW, CO, -1, 1'b1, rnd_words());               // reset mid-frame
        repeat (6) frame(FRAME, SW, CO, -1, 1'b0, nom);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            p = (r < 6) ? FRAME : (r == 6) ? $urandom_range(FRAME - 1, FRAME + 1) :
                (r == 7) ? $urandom_range(DB, 40) : (r == 8) ? 10 : 120;
            w    = ($urandom_range(0, 5) == 0) ? 6 : SW;
            conv = (p == 10) ? 5 : (($urandom_range(0, 5) == 0) ? 11 : CO);
            clr  = (p == FRAME && $urandom_range(0, 3) == 0) ? 45 : -1;
`ifdef ADC_RX_TESTPAT_EN
            tm_on = ($urandom_range(0, 2) == 0);
`endif
            frame(p, w, conv, clr, 1'b0, rnd_words());
        end
        tm_on = 1'b0;
        frame(FRAME, SW, CO, 45, 1'b0, nom);
        repeat (30) @(negedge PLL_clk_100MHz);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
